// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//   Pipeline-stage register with valid/ready flow control. Carries a control
//   bundle (cleared on bubbles so no spurious write-enables escape) and a data
//   bundle. With SKID=1 a second entry register absorbs one in-flight item, so
//   upstream ready comes straight from a flop. With SKID=0 the stage is a
//   single register and o_ready is combinational. A saturating counter
//   records cycles where downstream back-pressure held a valid entry.
//
// Ports
//   i_clk        clock, rising edge
//   i_resetn     asynchronous active-low reset
//   i_flush      synchronous flush: drops held and incoming entries
//   i_valid      upstream entry valid
//   o_ready      stage can accept an entry this cycle
//   i_ctrl       upstream control bundle  [CTRL_W]
//   i_data       upstream data bundle     [DATA_W]
//   o_valid      downstream entry valid
//   i_ready      downstream accepts entry
//   o_ctrl       downstream control bundle, 0 whenever o_valid=0
//   o_data       downstream data bundle (holds last value on bubbles)
//   o_stall_cnt  saturating count of cycles with o_valid && !i_ready
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 69,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing held
    ST_BUSY  = 2'd1,  // output register holds an entry
    ST_FULL  = 2'd2   // output and skid registers both hold entries
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_ready;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [DATA_W-1:0]   r_data;
  logic [CTRL_W-1:0]   r_sk_ctrl;
  logic [DATA_W-1:0]   r_sk_data;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic                w_accept;
  logic                w_emit;
  logic                w_load_in;   // output register <- upstream
  logic                w_load_sk;   // output register <- skid register
  logic                w_fill_sk;   // skid register   <- upstream

  assign o_valid     = (r_state != ST_EMPTY);
  assign o_ctrl      = r_ctrl;
  assign o_data      = r_data;
  assign o_stall_cnt = r_stall_cnt;

  // Without the skid register the stage can only take a new entry when the
  // current one leaves in the same cycle, so ready has to look at i_ready.
  // That also means BUSY never sees Accept without Emit, so FULL is never
  // reached when SKID=0 and r_ready stays 1.
  assign o_ready  = (SKID != 0) ? r_ready : (!o_valid || i_ready);

  assign w_accept = i_valid && o_ready;
  assign w_emit   = o_valid && i_ready;

  // Next-state and register-load decode. Flush overrides everything: the
  // stage empties and whatever is offered in the flush cycle is dropped.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nxt = r_state;
    w_load_in   = 1'b0;
    w_load_sk   = 1'b0;
    w_fill_sk   = 1'b0;
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_BUSY;
            w_load_in   = 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_accept && w_emit) begin
            w_load_in   = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = ST_FULL;
            w_fill_sk   = 1'b1;
          end else if (w_emit) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_emit) begin
            w_state_nxt = ST_BUSY;
            w_load_sk   = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State register; o_ready for the skid variant is precomputed from the
  // next state so it leaves the block directly from a flop.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= ST_EMPTY;
      r_ready <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments for all flops so every register
      // samples pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != ST_FULL);
    end
  end

  // Output and skid registers. The control bundle is zeroed whenever the
  // stage goes empty (bubble or flush); the data bundle simply holds.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      // NOTE: the data path is reset as well, because o_data=0 out of reset
      // is visible behaviour; the skid copy is cleared for determinism.
      r_ctrl    <= '0;
      r_data    <= '0;
      r_sk_ctrl <= '0;
      r_sk_data <= '0;
    end else begin
      if (w_load_in) begin
        r_ctrl <= i_ctrl;
        r_data <= i_data;
      end else if (w_load_sk) begin
        r_ctrl <= r_sk_ctrl;
        r_data <= r_sk_data;
      end else if (w_state_nxt == ST_EMPTY) begin
        r_ctrl <= '0;
      end
      if (w_fill_sk) begin
        r_sk_ctrl <= i_ctrl;
        r_sk_data <= i_data;
      end
    end
  end

  // Back-pressure counter: saturates, ignores flush, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_stall_cnt <= '0;
    end else if (o_valid && !i_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//   Drives one SKID=1 and one SKID=0 instance from shared stimulus; `sel`
//   picks which instance is observed. A negedge monitor keeps a FIFO
//   scoreboard of accepted entries and compares each emitted entry, and also
//   checks o_ctrl=0 whenever o_valid=0. Cycle tables and short hand-written
//   sequences cover back-pressure, flush, bubbles, reset and saturation.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int CTRL_W = 2;
  localparam int DATA_W = 69;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_flush, i_valid, i_ready;
  logic [CTRL_W-1:0] i_ctrl;
  logic [DATA_W-1:0] i_data;

  logic              ov1, or1, ov0, or0;
  logic [CTRL_W-1:0] oc1, oc0;
  logic [DATA_W-1:0] od1, od0;
  logic [CNT_W-1:0]  cnt1, cnt0;

  bit                sel;  // 1: observe SKID=1 instance, 0: SKID=0 instance
  logic              m_ov, m_or;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  m_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [CTRL_W+DATA_W-1:0] sb[$];
  logic [CTRL_W+DATA_W-1:0] sb_head;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(CNT_W)) u_dut_s1 (
    .i_clk(clk), .i_resetn(rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(or1),
    .i_ctrl(i_ctrl), .i_data(i_data), .o_valid(ov1), .i_ready(i_ready),
    .o_ctrl(oc1), .o_data(od1), .o_stall_cnt(cnt1));

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0), .CNT_W(CNT_W)) u_dut_s0 (
    .i_clk(clk), .i_resetn(rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(or0),
    .i_ctrl(i_ctrl), .i_data(i_data), .o_valid(ov0), .i_ready(i_ready),
    .o_ctrl(oc0), .o_data(od0), .o_stall_cnt(cnt0));

  assign m_ov   = sel ? ov1  : ov0;
  assign m_or   = sel ? or1  : or0;
  assign m_ctrl = sel ? oc1  : oc0;
  assign m_data = sel ? od1  : od0;
  assign m_cnt  = sel ? cnt1 : cnt0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (skid=%0d t=%0t): got %0h expected %0h", name, sel, $time, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input int k);
    logic [DATA_W-1:0] v;
    v = DATA_W'(k);
    return v | (v << 61);
  endfunction

  // Inputs are stable from posedge+1 to the next posedge, so the negedge
  // sees exactly what the DUT will act on at the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (!m_ov) check("ctrl_zero_when_idle", 128'(m_ctrl), 128'(0));
      if (m_ov && i_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_emit", 128'({m_ctrl, m_data}), 128'(0));
          n_err += (n_err == 0 && {m_ctrl, m_data} == '0) ? 1 : 0;
        end else begin
          sb_head = sb.pop_front();
          check("emit_order", 128'({m_ctrl, m_data}), 128'(sb_head));
        end
      end
      if (i_flush)                sb.delete();
      else if (i_valid && m_or)   sb.push_back({i_ctrl, i_data});
    end
  end

  task automatic drive(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input bit ir, input bit fl);
    @(posedge clk); #1;
    i_valid = v; i_ctrl = c; i_data = d; i_ready = ir; i_flush = fl;
  endtask

  task automatic idle(input int n, input bit ir);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, ir, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1; i_ctrl = '0; i_data = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit v;    int d;    bit ir;     // inputs for the cycle
    bit e_ov; int e_od; bit e_or;   // outputs expected during that cycle
  } vec_t;

  vec_t tab1[9];
  vec_t tab0[9];
  vec_t row;

  task automatic run_suite(input bit skid);
    sel = skid;
    do_reset();

    // Reset mid-stream with held entries and a non-zero stall count.
    drive(1'b1, 2'b01, mk_data(9), 1'b0, 1'b0);
    drive(1'b1, 2'b10, mk_data(10), 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 128'(m_ov),   128'(0));
    check("rst_ctrl",  128'(m_ctrl), 128'(0));
    check("rst_data",  128'(m_data), 128'(0));
    check("rst_ready", 128'(m_or),   128'(1));
    check("rst_cnt",   128'(m_cnt),  128'(0));
    @(posedge clk); #1; rst_n = 1'b1; i_ready = 1'b1;

    // Streaming 1..8 back-to-back with downstream always ready.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, CTRL_W'(k), mk_data(k), 1'b1, 1'b0);
      if (k > 1) begin
        check("stream_valid", 128'(m_ov), 128'(1));
        check("stream_data",  128'(m_data), 128'(mk_data(k - 1)));
      end
      check("stream_ready", 128'(m_or), 128'(1));
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("stream_last", 128'(m_data), 128'(mk_data(8)));
    idle(1, 1'b1);
    check("stream_drained", 128'(m_ov), 128'(0));
    check("stream_cnt", 128'(m_cnt), 128'(0));

    // Back-pressure for 3 cycles while item 2 is presented.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      row = skid ? tab1[c] : tab0[c];
      drive(row.v, CTRL_W'(row.d), mk_data(row.d), row.ir, 1'b0);
      @(negedge clk);
      check($sformatf("bp_valid[%0d]", c), 128'(m_ov), 128'(row.e_ov));
      check($sformatf("bp_ready[%0d]", c), 128'(m_or), 128'(row.e_or));
      if (row.e_ov) check($sformatf("bp_data[%0d]", c), 128'(m_data), 128'(mk_data(row.e_od)));
    end
    idle(1, 1'b1);
    check("bp_cnt", 128'(m_cnt), 128'(3));

    // Flush with the stage holding A (and B when a skid exists), C offered.
    do_reset();
    drive(1'b1, 2'b11, mk_data(16'hA), 1'b0, 1'b0);
    drive(1'b1, 2'b11, mk_data(16'hB), 1'b0, 1'b0);
    drive(1'b1, 2'b11, mk_data(16'hC), 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("flush_valid", 128'(m_ov),   128'(0));
    check("flush_ctrl",  128'(m_ctrl), 128'(0));
    check("flush_ready", 128'(m_or),   128'(1));
    idle(3, 1'b1);
    // Flush from BUSY: for SKID=1 ready is high, so E would be accepted
    // without the flush.
    drive(1'b1, 2'b01, mk_data(16'hD), 1'b0, 1'b0);
    drive(1'b1, 2'b10, mk_data(16'hE), 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("flush2_valid", 128'(m_ov), 128'(0));
    idle(3, 1'b1);
    check("flush_sb_empty", 128'(sb.size()), 128'(0));

    // Bubble: ctrl must clear after the entry leaves, data holds.
    drive(1'b1, 2'b11, mk_data(16'h55), 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("bubble_pre_ctrl", 128'(m_ctrl), 128'(2'b11));
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("bubble_valid", 128'(m_ov),   128'(0));
    check("bubble_ctrl",  128'(m_ctrl), 128'(0));
    check("bubble_data",  128'(m_data), 128'(mk_data(16'h55)));

    // Saturation: one entry held for 20 back-pressured cycles.
    do_reset();
    drive(1'b1, 2'b01, mk_data(7), 1'b0, 1'b0);
    idle(20, 1'b0);
    check("sat_valid", 128'(m_ov),  128'(1));
    check("sat_cnt",   128'(m_cnt), 128'(15));
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("sat_cnt_after_flush", 128'(m_cnt), 128'(15));
    check("sat_flush_valid", 128'(m_ov), 128'(0));
    idle(2, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    i_ctrl = '0; i_data = '0; sel = 1'b1;

    tab1 = '{'{1,1,1, 0,0,1}, '{1,2,1, 1,1,1}, '{1,3,0, 1,2,1},
             '{1,4,0, 1,2,0}, '{1,4,0, 1,2,0}, '{1,4,1, 1,2,0},
             '{1,4,1, 1,3,1}, '{0,0,1, 1,4,1}, '{0,0,1, 0,0,1}};
    tab0 = '{'{1,1,1, 0,0,1}, '{1,2,1, 1,1,1}, '{1,3,0, 1,2,0},
             '{1,3,0, 1,2,0}, '{1,3,0, 1,2,0}, '{1,3,1, 1,2,1},
             '{1,4,1, 1,3,1}, '{0,0,1, 1,4,1}, '{0,0,1, 0,0,1}};

    run_suite(1'b1);
    run_suite(1'b0);
    check("final_sb_empty", 128'(sb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
